// File: rtl/melody_seq.sv
// Note sequencer: walks a {tone,dur} note table and drives a buzzer driver's
// tone/en inputs, timing each note and the silent gap that follows it.
module melody_seq #(
   parameter int TICK_DIV   = 1_200_000,
   parameter int GAP_CYCLES = 12_000,
   parameter int ADDR_W     = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stop,
   input  logic              loop,
   output logic [ADDR_W-1:0] note_addr,
   input  logic [7:0]        note_data,
   output logic              buzzer_en,
   output logic [4:0]        tone,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_PLAY,
      S_GAP
   } state_t;

   localparam logic [23:0]       TICK_LEN  = 24'(TICK_DIV);
   localparam logic [23:0]       GAP_LAST  = 24'(GAP_CYCLES - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
   localparam logic [4:0]        END_MARK  = 5'd31;
   localparam logic [4:0]        TOP_NOTE  = 5'd21;

   state_t            state_q, state_d;
   logic [23:0]       cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              en_q, en_d;
   logic [4:0]        tone_q, tone_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic [4:0] nd_tone;
   logic [2:0] nd_dur;

   assign nd_tone = note_data[7:3];
   assign nd_dur  = note_data[2:0];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      en_d    = en_q;
      tone_d  = tone_q;
      done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            en_d = 1'b0;
            if (start && !stop) begin
               addr_d  = '0;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            if (nd_tone == END_MARK) begin
               // Looping only from a non-zero address avoids spinning on an empty song.
               if (loop && (addr_q != '0)) begin
                  addr_d = '0;
               end else begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end
            end else begin
               tone_d  = nd_tone;
               en_d    = (nd_tone != 5'd0) && (nd_tone <= TOP_NOTE);
               cnt_d   = (({21'd0, nd_dur} + 24'd1) * TICK_LEN) - 24'd1;
               state_d = S_PLAY;
            end
         end
         S_PLAY: begin
            if (cnt_q == 24'd0) begin
               en_d    = 1'b0;
               cnt_d   = GAP_LAST;
               state_d = S_GAP;
            end else begin
               cnt_d = cnt_q - 24'd1;
            end
         end
         S_GAP: begin
            if (cnt_q == 24'd0) begin
               if (addr_q == ADDR_LAST) begin
                  if (loop) begin
                     addr_d  = '0;
                     state_d = S_FETCH;
                  end else begin
                     done_d  = 1'b1;
                     state_d = S_IDLE;
                  end
               end else begin
                  addr_d  = addr_q + ADDR_W'(1);
                  state_d = S_FETCH;
               end
            end else begin
               cnt_d = cnt_q - 24'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            en_d    = 1'b0;
         end
      endcase

      // Abort overrides every other decision; tone and address keep their values.
      if ((state_q != S_IDLE) && stop) begin
         state_d = S_IDLE;
         cnt_d   = 24'd0;
         addr_d  = addr_q;
         en_d    = 1'b0;
         tone_d  = tone_q;
         done_d  = 1'b0;
      end

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= 24'd0;
         addr_q  <= '0;
         en_q    <= 1'b0;
         tone_q  <= 5'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         en_q    <= en_d;
         tone_q  <= tone_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign note_addr = addr_q;
   assign buzzer_en = en_q;
   assign tone      = tone_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_melody_seq.sv
// Bench for melody_seq: a song-walking reference model checked every cycle,
// directed scenarios with literal timing expectations, then random traffic.
module tb_melody_seq;

   localparam int TICK = 4;
   localparam int GAP  = 2;

   typedef logic lq_t[$];

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       stop;
   logic       loop;
   logic [2:0] note_addr;
   logic [7:0] note_data;
   logic       buzzer_en;
   logic [4:0] tone;
   logic       busy;
   logic       done;

   logic [7:0] tbl [8];

   int tests;
   int fails;

   // reference model outputs
   logic       m_busy;
   logic       m_en;
   logic [4:0] m_tone;
   logic [2:0] m_addr;
   logic       m_done;

   bit  logging;
   lq_t en_q;
   lq_t busy_q;
   lq_t done_q;
   logic [4:0] tone_q[$];
   logic [2:0] addr_q[$];

   melody_seq #(
      .TICK_DIV   (TICK),
      .GAP_CYCLES (GAP),
      .ADDR_W     (3)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .stop      (stop),
      .loop      (loop),
      .note_addr (note_addr),
      .note_data (note_data),
      .buzzer_en (buzzer_en),
      .tone      (tone),
      .busy      (busy),
      .done      (done)
   );

   assign note_data = tbl[note_addr];

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- reference model ----------------
   task automatic m_reset();
      m_busy = 1'b0;
      m_en   = 1'b0;
      m_tone = 5'd0;
      m_addr = 3'd0;
      m_done = 1'b0;
   endtask

   // One clock edge as seen by the song: ab=1 when reset or stop ended playback.
   task automatic adv(output bit ab);
      @(posedge clk or negedge rst_n);
      ab = 1'b0;
      if (rst_n !== 1'b1) begin
         m_reset();
         ab = 1'b1;
      end else if (m_busy && stop) begin
         m_busy = 1'b0;
         m_en   = 1'b0;
         m_done = 1'b0;
         ab     = 1'b1;
      end
   endtask

   task automatic play_song();
      bit         ab;
      logic [2:0] a;
      logic [7:0] w;
      int         n;
      a = 3'd0;
      forever begin
         w = tbl[a];
         adv(ab);
         if (ab) return;
         if (w[7:3] == 5'd31) begin
            if (loop && a != 3'd0) begin
               a      = 3'd0;
               m_addr = 3'd0;
               continue;
            end
            m_busy = 1'b0;
            m_done = 1'b1;
            return;
         end
         m_en   = (w[7:3] >= 5'd1) && (w[7:3] <= 5'd21);
         m_tone = w[7:3];
         n      = (int'(w[2:0]) + 1) * TICK;
         for (int i = 1; i < n; i++) begin
            adv(ab);
            if (ab) return;
         end
         adv(ab);
         if (ab) return;
         m_en = 1'b0;
         for (int i = 1; i < GAP; i++) begin
            adv(ab);
            if (ab) return;
         end
         adv(ab);
         if (ab) return;
         if (a == 3'd7) begin
            if (loop) begin
               a = 3'd0;
            end else begin
               m_busy = 1'b0;
               m_done = 1'b1;
               return;
            end
         end else begin
            a = a + 3'd1;
         end
         m_addr = a;
      end
   endtask

   initial begin
      bit ab;
      m_reset();
      forever begin
         if (rst_n !== 1'b1) begin
            m_reset();
            wait (rst_n === 1'b1);
         end
         adv(ab);
         if (!ab) begin
            m_done = 1'b0;
            if (start && !stop) begin
               m_busy = 1'b1;
               m_en   = 1'b0;
               m_addr = 3'd0;
               play_song();
            end
         end
      end
   end

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int ones(input lq_t q);
      int c;
      c = 0;
      foreach (q[i]) if (q[i] === 1'b1) c++;
      return c;
   endfunction

   // Falling edge: compare DUT against model, log, then step off the edge to drive.
   task automatic tick();
      @(negedge clk);
      tests++;
      if ({busy, buzzer_en, tone, note_addr, done} !== {m_busy, m_en, m_tone, m_addr, m_done}) begin
         fails++;
         $display("FAIL model_cycle t=%0t: got busy=%b en=%b tone=%0d addr=%0d done=%b expected busy=%b en=%b tone=%0d addr=%0d done=%b",
                  $time, busy, buzzer_en, tone, note_addr, done, m_busy, m_en, m_tone, m_addr, m_done);
      end
      if (logging) begin
         en_q.push_back(buzzer_en);
         busy_q.push_back(busy);
         done_q.push_back(done);
         tone_q.push_back(tone);
         addr_q.push_back(note_addr);
      end
      #1;
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   // Log index 0 is the FETCH cycle right after start is sampled.
   task automatic start_song();
      tick();
      en_q.delete();
      busy_q.delete();
      done_q.delete();
      tone_q.delete();
      addr_q.delete();
      logging = 1'b1;
      start   = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic set_basic();
      tbl[0] = 8'h08;
      tbl[1] = 8'h29;
      tbl[2] = 8'hF8;
      for (int i = 3; i < 8; i++) tbl[i] = 8'h00;
   endtask

   task automatic rand_table();
      int r;
      for (int i = 0; i < 8; i++) begin
         r = $urandom_range(0, 19);
         if (r < 3)      tbl[i] = {5'd31, 3'($urandom_range(0, 7))};
         else if (r < 6) tbl[i] = {5'($urandom_range(22, 30)), 3'($urandom_range(0, 7))};
         else if (r < 7) tbl[i] = {5'd0, 3'($urandom_range(0, 7))};
         else            tbl[i] = {5'($urandom_range(1, 21)), 3'($urandom_range(0, 7))};
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      tests   = 0;
      fails   = 0;
      logging = 1'b0;
      start   = 1'b0;
      stop    = 1'b0;
      loop    = 1'b0;
      set_basic();
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      run(3);
      chk("reset_busy", busy, 0);
      chk("reset_en", buzzer_en, 0);
      chk("reset_tone", tone, 0);
      chk("reset_addr", note_addr, 0);
      chk("reset_done", done, 0);
      rst_n = 1'b1;
      run(3);

      // basic song: 4 high (tone 1), 3 low, 8 high (tone 5), then done
      start_song();
      run(25);
      chk("basic_fetch_busy", busy_q[0], 1);
      chk("basic_fetch_en", en_q[0], 0);
      chk("basic_n1_first", en_q[1], 1);
      chk("basic_n1_tone", tone_q[1], 1);
      chk("basic_n1_last", en_q[4], 1);
      chk("basic_gap_first", en_q[5], 0);
      chk("basic_gap_last", en_q[7], 0);
      chk("basic_n2_first", en_q[8], 1);
      chk("basic_n2_tone", tone_q[8], 5);
      chk("basic_n2_last", en_q[15], 1);
      chk("basic_n2_end", en_q[16], 0);
      chk("basic_en_total", ones(en_q), 12);
      chk("basic_done_at", done_q[19], 1);
      chk("basic_busy_fall", busy_q[19], 0);
      chk("basic_busy_before", busy_q[18], 1);
      chk("basic_done_count", ones(done_q), 1);

      // rest of 4 ticks, then tone 2
      tbl[0] = 8'h03;
      tbl[1] = 8'h10;
      tbl[2] = 8'hF8;
      start_song();
      run(35);
      chk("rest_en_quiet", ones(en_q[0:19]), 0);
      chk("rest_tone2_on", en_q[20], 1);
      chk("rest_tone2_val", tone_q[20], 2);
      chk("rest_done_count", ones(done_q), 1);

      // loop: replay without done, then done after loop drops
      set_basic();
      loop = 1'b1;
      start_song();
      run(40);
      chk("loop_end_fetch_addr", addr_q[18], 2);
      chk("loop_restart_addr", addr_q[19], 0);
      chk("loop_restart_busy", busy_q[19], 1);
      chk("loop_replay_en", en_q[20], 1);
      chk("loop_replay_tone", tone_q[20], 1);
      chk("loop_no_done", ones(done_q), 0);
      loop = 1'b0;
      run(40);
      chk("loop_exit_done_at", done_q[57], 1);
      chk("loop_exit_done_count", ones(done_q), 1);

      // stop mid-play
      start_song();
      run(3);
      chk("stop_pre_en", en_q[3], 1);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      run(4);
      chk("stop_en", en_q[4], 0);
      chk("stop_busy", busy_q[4], 0);
      chk("stop_tone_hold", tone_q[4], 1);
      chk("stop_no_done", ones(done_q), 0);
      start = 1'b1;
      stop  = 1'b1;
      tick();
      start = 1'b0;
      stop  = 1'b0;
      tick();
      chk("start_stop_idle_busy", busy, 0);
      run(2);
      chk("start_stop_idle_busy2", busy, 0);

      // table end without marker
      for (int k = 0; k < 8; k++) tbl[k] = {5'(k + 1), 3'd0};
      start_song();
      run(60);
      chk("wrap_last_tone", tone_q[53], 8);
      chk("wrap_done_at", done_q[56], 1);
      chk("wrap_addr_hold", addr_q[56], 7);
      chk("wrap_busy_fall", busy_q[56], 0);
      chk("wrap_done_count", ones(done_q), 1);

      // end marker at address 0 with loop set
      tbl[0] = 8'hF8;
      loop   = 1'b1;
      start_song();
      run(3);
      chk("empty_fetch_busy", busy_q[0], 1);
      chk("empty_done_at", done_q[1], 1);
      chk("empty_busy_fall", busy_q[1], 0);
      chk("empty_done_count", ones(done_q), 1);
      loop = 1'b0;

      // asynchronous reset mid-note
      set_basic();
      start_song();
      run(2);
      chk("rst_pre_en", buzzer_en, 1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_en", buzzer_en, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_tone", tone, 0);
      chk("rst_mid_addr", note_addr, 0);
      chk("rst_mid_done", done, 0);
      run(3);
      rst_n = 1'b1;
      run(5);
      chk("rst_after_idle", busy, 0);
      logging = 1'b0;

      // random traffic against the model
      loop = 1'b0;
      for (int c = 0; c < 5000; c++) begin
         tick();
         if (!m_busy && $urandom_range(0, 3) == 0) rand_table();
         start = ($urandom_range(0, 14) == 0);
         stop  = ($urandom_range(0, 69) == 0);
         if ($urandom_range(0, 79) == 0) loop = ~loop;
      end
      start = 1'b0;
      loop  = 1'b0;
      stop  = 1'b1;
      tick();
      stop = 1'b0;
      run(3);
      chk("final_idle", busy, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/melody_seq.md
# melody_seq

Note sequencer that plays a stored melody on the buzzer driver. It steps through a note table, one 8-bit word per note, and drives the driver's `tone` and `en` inputs, timing each note's duration and the silent gap between notes. It sits between the top level (start/stop/loop controls plus the note table) and the existing buzzer instance. The top level now drives `buzzer_en`/`tone` from this block instead of from its fixed 1 s tone sweep.

## Interface
- `TICK_DIV`, 1_200_000: clock cycles per duration tick (100 ms at 12 MHz).
- `GAP_CYCLES`, 12_000: cycles with `en` low between consecutive notes; must be ≥1.
- `ADDR_W`, 5: note-table address width (up to 32 entries).
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle pulse; begins playback at address 0.
- `stop`  in  1  single-cycle pulse; aborts playback.
- `loop`  in  1  level; when 1, the end of the song restarts it from address 0.
- `note_addr`  out  ADDR_W  table read address (registered).
- `note_data`  in  8  table word `{tone[4:0], dur[2:0]}`, combinationally valid for the current `note_addr`.
- `buzzer_en`  out  1  connects to the buzzer driver `en`.
- `tone`  out  5  connects to the buzzer driver `tone`.
- `busy`  out  1  high while not IDLE.
- `done`  out  1  one-cycle pulse on natural song end.

## Operation
- Note word decode:
  - `tone` 1..21 is an audible note.
  - `tone` 0 and 22..30 are rests: `buzzer_en` stays 0 for the full duration.
  - `tone` 31 is the end marker.
  - Note length is (dur+1)·TICK_DIV cycles, i.e. 1..8 ticks.
- Duration counter is 24 bits; the constraint is 8·TICK_DIV ≤ 2^24.
- All outputs are registered.
- FSM states:
  - **IDLE**:
    - `busy`=0, `buzzer_en`=0.
    - `start`=1 sets `note_addr`=0 and goes to FETCH.
  - **FETCH** (1 cycle), which samples `note_data`:
    - End marker, loop=1, `note_addr`≠0: set `note_addr`=0 and stay in FETCH.
    - End marker, with loop=0 or `note_addr`=0: pulse `done` and go to IDLE. This prevents an empty-song spin.
    - Otherwise: latch `tone`, load the duration count, set `buzzer_en`=1 only if the tone is 1..21, then go to PLAY.
  - **PLAY**: count (dur+1)·TICK_DIV cycles, then set `buzzer_en`=0 and go to GAP.
  - **GAP**: count GAP_CYCLES cycles, then go to FETCH.
    - Normally `note_addr` increments by 1.
    - If `note_addr` = 2^ADDR_W−1, the table end counts as the end marker: wrap to 0 if loop=1, else pulse `done` and go to IDLE.
- The GAP forces an `en` 1→0→1 edge between equal consecutive notes, so the driver retriggers.
- `stop` in any non-IDLE state: next state is IDLE, `buzzer_en`=0, `done` is not pulsed, and `tone` holds its value.
- `start` while busy is ignored.
- `start` and `stop` together in IDLE: `stop` wins and the block stays IDLE.
- `loop` is sampled only at the end-of-song decision.
- `tone` holds its last latched value after a note ends and during IDLE.

## Timing
- Reset values: `note_addr`=0, `buzzer_en`=0, `tone`=0, `busy`=0, `done`=0, state IDLE, counters 0.
- Reset mid-note drops `buzzer_en` immediately (asynchronous).
- `start` sampled at edge k: `busy`=1 from edge k, FETCH during cycle k+1, `buzzer_en`/`tone` valid from edge k+1.
- `buzzer_en` is high for exactly (dur+1)·TICK_DIV cycles per audible note.
- Note period is (dur+1)·TICK_DIV + GAP_CYCLES + 1 cycles: play, gap, fetch.
- `done` is asserted for one cycle, coincident with `busy` falling.
- `stop` sampled at edge k: `buzzer_en`=0 and `busy`=0 from edge k+1.
- A loop restart spends one FETCH cycle reading address 0.

## Test plan
Bench parameters are TICK_DIV=4, GAP_CYCLES=2, ADDR_W=3 unless a scenario says otherwise.
- **Basic song**: table {0x08, 0x29, 0xF8}, i.e. tone1/dur0, tone5/dur1, end; `start` pulse.
  - Required: `en` high 4 cycles with tone 1, low 3 cycles, high 8 cycles with tone 5.
  - Then `done` pulses and `busy` falls.
- **Rest**: table {0x03, 0x10, 0xF8}, i.e. a rest of 4 ticks, then tone 2.
  - Required: `en` stays 0 for 16+3 cycles, then goes high with tone 2.
- **Loop**: same song as the basic case with loop=1.
  - Required: after the end marker, `note_addr` returns to 0 and tone 1 replays; no `done` pulse.
  - Deassert loop: the next end marker gives `done`.
- **Stop**: `stop` pulse mid-PLAY.
  - Required: `en`=0 and `busy`=0 the next cycle, no `done`, `tone` holds.
  - Assert `start` and `stop` together in IDLE: block stays IDLE.
- **Table wrap**: 8 audible entries with no end marker, loop=0.
  - Required: after address 7, `done` pulses and `note_addr` does not wrap.
  - End marker at address 0 with loop=1: `done` after one FETCH cycle.
- **Reset mid-note**: assert `rst_n`=0 while `en`=1.
  - Required: all outputs go to their reset values immediately.
  - After release, the block stays IDLE until `start`.
